// File: rtl/mem_stage.sv
// Memory-access pipeline stage: accepts one instruction from execute, performs a
// data-memory load or store over a valid/ready request port and a valid response
// port, formats load data, and hands a registered result to writeback.
module mem_stage (
  input  logic        clk_i,
  input  logic        reset_n_i,
  // Execute side
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic        ex_is_load_i,
  input  logic        ex_is_store_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [1:0]  ex_rdmux_sel_i,
  input  logic        ex_rd_we_i,
  // Data memory
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_rdata_i,
  // Writeback side
  output logic        wb_valid_o,
  output logic [31:0] wb_pc_o,
  output logic [31:0] wb_ld_result_o,
  output logic [31:0] wb_alu_result_o,
  output logic [1:0]  wb_rdmux_sel_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_rd_we_o,
  output logic        wb_misalign_o
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] alu_q;
  logic [2:0]  funct3_q;
  logic        is_load_q;
  logic [4:0]  rd_q;
  logic [1:0]  rdmux_q;
  logic        rd_we_q;

  logic [1:0]  ex_off;
  logic        ex_trap;
  logic        ex_is_mem;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic [31:0] ld_shifted;
  logic [31:0] ld_data;

  assign ex_off     = ex_alu_result_i[1:0];
  assign ex_is_mem  = ex_is_load_i | ex_is_store_i;
  assign ex_ready_o = (state_q == StIdle);

  // Trap detection on the incoming instruction: illegal width or misaligned address.
  always_comb begin
    ex_trap = 1'b0;
    if (ex_is_load_i) begin
      unique case (ex_funct3_i)
        3'b000, 3'b100: ex_trap = 1'b0;
        3'b001, 3'b101: ex_trap = ex_off[0];
        3'b010:         ex_trap = (ex_off != 2'b00);
        default:        ex_trap = 1'b1;
      endcase
    end else if (ex_is_store_i) begin
      unique case (ex_funct3_i)
        3'b000:  ex_trap = 1'b0;
        3'b001:  ex_trap = ex_off[0];
        3'b010:  ex_trap = (ex_off != 2'b00);
        default: ex_trap = 1'b1;
      endcase
    end
  end

  // Store lane steering: byte/half moved to the lane selected by the low address bits.
  always_comb begin
    st_mask  = 4'b1111;
    st_wdata = ex_store_data_i;
    unique case (ex_funct3_i[1:0])
      2'b00: begin
        st_mask  = 4'b0001 << ex_off;
        st_wdata = {24'h0, ex_store_data_i[7:0]} << {ex_off, 3'b000};
      end
      2'b01: begin
        st_mask  = 4'b0011 << ex_off;
        st_wdata = {16'h0, ex_store_data_i[15:0]} << {ex_off, 3'b000};
      end
      default: begin
        st_mask  = 4'b1111;
        st_wdata = ex_store_data_i;
      end
    endcase
  end

  // Load formatting: extract the addressed byte/half and sign- or zero-extend.
  always_comb begin
    ld_shifted = mem_rdata_i >> {alu_q[1:0], 3'b000};
    ld_data    = mem_rdata_i;
    unique case (funct3_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b100:  ld_data = {24'h0, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b101:  ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Control FSM with registered request and writeback outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q         <= StIdle;
      pc_q            <= '0;
      alu_q           <= '0;
      funct3_q        <= '0;
      is_load_q       <= 1'b0;
      rd_q            <= '0;
      rdmux_q         <= '0;
      rd_we_q         <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_addr_o      <= '0;
      mem_we_o        <= 1'b0;
      mem_wmask_o     <= '0;
      mem_wdata_o     <= '0;
      wb_valid_o      <= 1'b0;
      wb_pc_o         <= '0;
      wb_ld_result_o  <= '0;
      wb_alu_result_o <= '0;
      wb_rdmux_sel_o  <= '0;
      wb_rd_o         <= '0;
      wb_rd_we_o      <= 1'b0;
      wb_misalign_o   <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ex_valid_i) begin
            pc_q      <= ex_pc_i;
            alu_q     <= ex_alu_result_i;
            funct3_q  <= ex_funct3_i;
            is_load_q <= ex_is_load_i;
            rd_q      <= ex_rd_i;
            rdmux_q   <= ex_rdmux_sel_i;
            rd_we_q   <= ex_rd_we_i & ~ex_is_store_i;
            if (ex_is_mem && !ex_trap) begin
              state_q         <= StReq;
              mem_req_valid_o <= 1'b1;
              mem_addr_o      <= {ex_alu_result_i[31:2], 2'b00};
              mem_we_o        <= ex_is_store_i;
              mem_wmask_o     <= ex_is_store_i ? st_mask : 4'b0000;
              mem_wdata_o     <= ex_is_store_i ? st_wdata : 32'h0;
            end else begin
              // Non-memory or trapped op completes directly from IDLE.
              wb_valid_o      <= 1'b1;
              wb_pc_o         <= ex_pc_i;
              wb_ld_result_o  <= '0;
              wb_alu_result_o <= ex_alu_result_i;
              wb_rdmux_sel_o  <= ex_rdmux_sel_i;
              wb_rd_o         <= ex_rd_i;
              wb_rd_we_o      <= ex_rd_we_i & ~ex_is_store_i & ~ex_trap;
              wb_misalign_o   <= ex_trap;
            end
          end
        end
        StReq: begin
          // A response arriving in the handshake cycle is deliberately ignored.
          if (mem_req_ready_i) begin
            state_q         <= StResp;
            mem_req_valid_o <= 1'b0;
          end
        end
        StResp: begin
          if (mem_resp_valid_i) begin
            state_q         <= StIdle;
            wb_valid_o      <= 1'b1;
            wb_pc_o         <= pc_q;
            wb_ld_result_o  <= is_load_q ? ld_data : 32'h0;
            wb_alu_result_o <= alu_q;
            wb_rdmux_sel_o  <= rdmux_q;
            wb_rd_o         <= rd_q;
            wb_rd_we_o      <= rd_we_q;
            wb_misalign_o   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [31:0] ex_pc_i = '0;
  logic [31:0] ex_alu_result_i = '0;
  logic [31:0] ex_store_data_i = '0;
  logic [2:0]  ex_funct3_i = '0;
  logic        ex_is_load_i = 1'b0;
  logic        ex_is_store_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;
  logic [1:0]  ex_rdmux_sel_i = '0;
  logic        ex_rd_we_i = 1'b0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_wdata_o;
  logic        mem_resp_valid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        wb_valid_o;
  logic [31:0] wb_pc_o;
  logic [31:0] wb_ld_result_o;
  logic [31:0] wb_alu_result_o;
  logic [1:0]  wb_rdmux_sel_o;
  logic [4:0]  wb_rd_o;
  logic        wb_rd_we_o;
  logic        wb_misalign_o;

  int n_vec = 0;
  int n_err = 0;

  mem_stage dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_pc_i(ex_pc_i),
    .ex_alu_result_i(ex_alu_result_i), .ex_store_data_i(ex_store_data_i),
    .ex_funct3_i(ex_funct3_i), .ex_is_load_i(ex_is_load_i), .ex_is_store_i(ex_is_store_i),
    .ex_rd_i(ex_rd_i), .ex_rdmux_sel_i(ex_rdmux_sel_i), .ex_rd_we_i(ex_rd_we_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wmask_o(mem_wmask_o),
    .mem_wdata_o(mem_wdata_o), .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o), .wb_ld_result_o(wb_ld_result_o),
    .wb_alu_result_o(wb_alu_result_o), .wb_rdmux_sel_o(wb_rdmux_sel_o), .wb_rd_o(wb_rd_o),
    .wb_rd_we_o(wb_rd_we_o), .wb_misalign_o(wb_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Observations from one transaction
  int          obs_lat, obs_pulses, obs_unstable, obs_ready_busy;
  logic        obs_req_seen;
  logic [31:0] obs_addr, obs_wdata;
  logic        obs_we;
  logic [3:0]  obs_mask;
  logic [31:0] obs_pc, obs_ld, obs_alu;
  logic [1:0]  obs_sel;
  logic [4:0]  obs_rd;
  logic        obs_rd_we, obs_mis;

  // ---------------- Reference model (from the access rules, plain arithmetic) --------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_trap(input logic ld, input logic st, input logic [2:0] f3,
                                      input logic [31:0] addr);
    logic legal;
    if (!ld && !st) return 1'b0;
    if (ld) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else    legal = (f3 <= 2);
    if (!legal) return 1'b1;
    return (addr % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    longint off, sz, v, span;
    off  = addr % 4;
    sz   = acc_size(f3);
    span = longint'(1) << (8 * sz);
    v    = (longint'(word) / (longint'(1) << (8 * off))) % span;
    if (f3[2] == 1'b0 && sz < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << acc_size(f3)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] d);
    longint v;
    v = (longint'(d) % (longint'(1) << (8 * acc_size(f3)))) * (longint'(1) << (8 * (addr % 4)));
    return v[31:0];
  endfunction

  // ---------------- Driver: issue one instruction, play memory, record outputs ------------
  task automatic run_txn(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [2:0] f3, input logic ld, input logic st,
                         input logic [4:0] rd, input logic [1:0] sel, input logic we,
                         input logic [31:0] rdata, input int req_stall, input int resp_wait);
    int phase, stall_cnt, wait_cnt;
    obs_lat = -1; obs_pulses = 0; obs_unstable = 0; obs_ready_busy = 0; obs_req_seen = 1'b0;
    phase = 0; stall_cnt = 0; wait_cnt = 0;
    ex_pc_i = pc; ex_alu_result_i = alu; ex_store_data_i = sd; ex_funct3_i = f3;
    ex_is_load_i = ld; ex_is_store_i = st; ex_rd_i = rd; ex_rdmux_sel_i = sel; ex_rd_we_i = we;
    ex_valid_i = 1'b1;
    @(posedge clk_i); #1;
    ex_valid_i = 1'b0;
    ex_alu_result_i = $urandom; ex_store_data_i = $urandom; ex_pc_i = $urandom;
    for (int c = 1; c <= 60; c++) begin
      if (wb_valid_o) begin
        if (obs_pulses == 0) begin
          obs_lat = c; obs_pc = wb_pc_o; obs_ld = wb_ld_result_o; obs_alu = wb_alu_result_o;
          obs_sel = wb_rdmux_sel_o; obs_rd = wb_rd_o; obs_rd_we = wb_rd_we_o;
          obs_mis = wb_misalign_o;
        end
        obs_pulses++;
      end
      if (obs_pulses == 0 && ex_ready_o) obs_ready_busy++;
      if (mem_req_valid_o) begin
        if (!obs_req_seen) begin
          obs_addr = mem_addr_o; obs_we = mem_we_o; obs_mask = mem_wmask_o;
          obs_wdata = mem_wdata_o; obs_req_seen = 1'b1;
        end else if (obs_addr !== mem_addr_o || obs_we !== mem_we_o ||
                     obs_mask !== mem_wmask_o || obs_wdata !== mem_wdata_o) begin
          obs_unstable++;
        end
      end
      mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = $urandom;
      if (phase == 0 && mem_req_valid_o) begin
        if (stall_cnt == req_stall) begin
          mem_req_ready_i = 1'b1;
          mem_resp_valid_i = 1'b1;  // coincident response must be ignored
          phase = 1;
        end else stall_cnt++;
      end else if (phase == 1) begin
        if (wait_cnt == resp_wait) begin
          mem_resp_valid_i = 1'b1; mem_rdata_i = rdata; phase = 2;
        end else wait_cnt++;
      end
      if (obs_pulses > 0 && c > obs_lat) break;
      @(posedge clk_i); #1;
    end
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
    // Return to IDLE if the stage is stuck, so later tests are still meaningful.
    if (!ex_ready_o) begin
      reset_n_i = 1'b0; @(posedge clk_i); #1; reset_n_i = 1'b1;
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_vec++;
    if ({mem_req_valid_o, wb_valid_o, wb_misalign_o, wb_rd_we_o, ex_ready_o} !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 00001",
               {mem_req_valid_o, wb_valid_o, wb_misalign_o, wb_rd_we_o, ex_ready_o});
    end
    n_vec++;
    if ({mem_addr_o, mem_wdata_o, mem_wmask_o, mem_we_o, wb_pc_o, wb_ld_result_o,
         wb_alu_result_o, wb_rd_o, wb_rdmux_sel_o} !== '0) begin
      n_err++;
      $display("FAIL reset_data got addr=%h wdata=%h mask=%b pc=%h ld=%h alu=%h want all 0",
               mem_addr_o, mem_wdata_o, mem_wmask_o, wb_pc_o, wb_ld_result_o, wb_alu_result_o);
    end
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_alu_op();
    run_txn(32'h100, 32'h1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd7, 2'd0, 1'b1, 32'h0, 0, 0);
    n_vec++; if (obs_lat !== 1) begin n_err++; $display("FAIL alu_lat got %0d want 1", obs_lat); end
    n_vec++; if (obs_pulses !== 1) begin n_err++; $display("FAIL alu_pulses got %0d want 1", obs_pulses); end
    n_vec++; if (obs_alu !== 32'h1234 || obs_pc !== 32'h100 || obs_ld !== 32'h0) begin
      n_err++; $display("FAIL alu_data got alu=%h pc=%h ld=%h want 1234 100 0", obs_alu, obs_pc, obs_ld);
    end
    n_vec++; if (obs_rd_we !== 1'b1 || obs_rd !== 5'd7 || obs_mis !== 1'b0 || obs_req_seen !== 1'b0) begin
      n_err++; $display("FAIL alu_ctrl got we=%b rd=%0d mis=%b req=%b want 1 7 0 0",
                        obs_rd_we, obs_rd, obs_mis, obs_req_seen);
    end
  endtask

  task automatic test_byte_loads();
    run_txn(32'h200, 32'h2003, 32'h0, 3'b000, 1'b1, 1'b0, 5'd3, 2'd2, 1'b1, 32'h80FF_0000, 0, 0);
    n_vec++; if (obs_addr !== 32'h2000) begin n_err++; $display("FAIL lb_addr got %h want 00002000", obs_addr); end
    n_vec++; if (obs_ld !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data got %h want ffffff80", obs_ld); end
    n_vec++; if (obs_lat !== 3) begin n_err++; $display("FAIL lb_lat got %0d want 3", obs_lat); end
    run_txn(32'h204, 32'h2003, 32'h0, 3'b100, 1'b1, 1'b0, 5'd3, 2'd2, 1'b1, 32'h80FF_0000, 0, 0);
    n_vec++; if (obs_ld !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_data got %h want 00000080", obs_ld); end
    n_vec++; if (obs_lat !== 3 || obs_rd_we !== 1'b1) begin
      n_err++; $display("FAIL lbu_lat got %0d we=%b want 3 1", obs_lat, obs_rd_we);
    end
  endtask

  task automatic test_store_half();
    run_txn(32'h300, 32'h2002, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 5'd9, 2'd0, 1'b1, 32'h0, 0, 0);
    n_vec++; if (obs_mask !== 4'b1100) begin n_err++; $display("FAIL sh_mask got %b want 1100", obs_mask); end
    n_vec++; if (obs_wdata !== 32'hABCD_0000) begin n_err++; $display("FAIL sh_wdata got %h want abcd0000", obs_wdata); end
    n_vec++; if (obs_we !== 1'b1 || obs_rd_we !== 1'b0 || obs_ld !== 32'h0) begin
      n_err++; $display("FAIL sh_ctrl got we=%b rd_we=%b ld=%h want 1 0 0", obs_we, obs_rd_we, obs_ld);
    end
  endtask

  task automatic test_trap();
    run_txn(32'h400, 32'h2002, 32'h0, 3'b010, 1'b1, 1'b0, 5'd4, 2'd2, 1'b1, 32'h0, 0, 0);
    n_vec++; if (obs_req_seen !== 1'b0 || obs_mis !== 1'b1 || obs_rd_we !== 1'b0 || obs_lat !== 1) begin
      n_err++; $display("FAIL trap_lw got req=%b mis=%b we=%b lat=%0d want 0 1 0 1",
                        obs_req_seen, obs_mis, obs_rd_we, obs_lat);
    end
    run_txn(32'h404, 32'h2000, 32'h0, 3'b011, 1'b1, 1'b0, 5'd4, 2'd2, 1'b1, 32'h0, 0, 0);
    n_vec++; if (obs_req_seen !== 1'b0 || obs_mis !== 1'b1 || obs_rd_we !== 1'b0 || obs_lat !== 1) begin
      n_err++; $display("FAIL trap_f3 got req=%b mis=%b we=%b lat=%0d want 0 1 0 1",
                        obs_req_seen, obs_mis, obs_rd_we, obs_lat);
    end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = $urandom;
    run_txn(32'h500, 32'h3000, 32'h0, 3'b010, 1'b1, 1'b0, 5'd5, 2'd2, 1'b1, w, 3, 2);
    n_vec++; if (obs_unstable !== 0 || obs_ready_busy !== 0) begin
      n_err++; $display("FAIL stall_hold got unstable=%0d ready_busy=%0d want 0 0",
                        obs_unstable, obs_ready_busy);
    end
    n_vec++; if (obs_pulses !== 1 || obs_lat !== 8) begin
      n_err++; $display("FAIL stall_pulse got pulses=%0d lat=%0d want 1 8", obs_pulses, obs_lat);
    end
    n_vec++; if (obs_ld !== w) begin n_err++; $display("FAIL stall_data got %h want %h", obs_ld, w); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    ex_alu_result_i = 32'h4000; ex_funct3_i = 3'b010; ex_is_load_i = 1'b1; ex_is_store_i = 1'b0;
    ex_rd_we_i = 1'b1; ex_valid_i = 1'b1;
    @(posedge clk_i); #1;             // REQ
    ex_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(posedge clk_i); #1;             // RESP
    mem_req_ready_i = 1'b0; reset_n_i = 1'b0;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1; mem_resp_valid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    mem_resp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (wb_valid_o) pulses++;
      @(posedge clk_i); #1;
    end
    n_vec++; if (pulses !== 0 || ex_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_ctrl got pulses=%0d ready=%b req=%b want 0 1 0",
                        pulses, ex_ready_o, mem_req_valid_o);
    end
    n_vec++; if ({wb_ld_result_o, wb_pc_o, mem_addr_o, wb_rd_we_o} !== '0) begin
      n_err++; $display("FAIL rst_mid_data got ld=%h pc=%h addr=%h we=%b want 0",
                        wb_ld_result_o, wb_pc_o, mem_addr_o, wb_rd_we_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, a1;
    a0 = $urandom; a1 = $urandom;
    ex_is_load_i = 1'b0; ex_is_store_i = 1'b0; ex_rd_we_i = 1'b1;
    ex_alu_result_i = a0; ex_valid_i = 1'b1;
    @(posedge clk_i); #1;
    n_vec++; if (wb_valid_o !== 1'b1 || ex_ready_o !== 1'b1 || wb_alu_result_o !== a0) begin
      n_err++; $display("FAIL b2b_first got v=%b rdy=%b alu=%h want 1 1 %h",
                        wb_valid_o, ex_ready_o, wb_alu_result_o, a0);
    end
    ex_alu_result_i = a1;
    @(posedge clk_i); #1;
    ex_valid_i = 1'b0;
    n_vec++; if (wb_valid_o !== 1'b1 || wb_alu_result_o !== a1) begin
      n_err++; $display("FAIL b2b_second got v=%b alu=%h want 1 %h", wb_valid_o, wb_alu_result_o, a1);
    end
    @(posedge clk_i); #1;
    n_vec++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_end got v=%b want 0", wb_valid_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] pc, addr, sd, word, exp_ld;
      logic [2:0]  f3;
      logic        ld, st, we, trap, is_mem;
      logic [4:0]  rd;
      logic [1:0]  sel;
      int          kind, rs, rw, exp_lat;
      kind = $urandom_range(0, 2);
      ld = (kind == 1); st = (kind == 2);
      f3 = 3'($urandom_range(0, 7));
      pc = $urandom; addr = $urandom; sd = $urandom; word = $urandom;
      rd = 5'($urandom); sel = 2'($urandom); we = 1'($urandom);
      rs = $urandom_range(0, 2); rw = $urandom_range(0, 2);
      run_txn(pc, addr, sd, f3, ld, st, rd, sel, we, word, rs, rw);
      trap    = model_trap(ld, st, f3, addr);
      is_mem  = (ld || st) && !trap;
      exp_lat = is_mem ? 3 + rs + rw : 1;
      exp_ld  = (ld && !trap) ? model_load(f3, addr, word) : 32'h0;
      n_vec++; if (obs_pulses !== 1 || obs_lat !== exp_lat) begin
        n_err++; $display("FAIL rnd%0d_timing got pulses=%0d lat=%0d want 1 %0d", i, obs_pulses, obs_lat, exp_lat);
      end
      n_vec++; if (obs_mis !== trap || obs_rd_we !== (we && !st && !trap) || obs_req_seen !== is_mem) begin
        n_err++; $display("FAIL rnd%0d_ctrl got mis=%b we=%b req=%b want %b %b %b", i, obs_mis,
                          obs_rd_we, obs_req_seen, trap, we && !st && !trap, is_mem);
      end
      n_vec++; if (obs_ld !== exp_ld || obs_alu !== addr || obs_pc !== pc || obs_rd !== rd || obs_sel !== sel) begin
        n_err++; $display("FAIL rnd%0d_wb got ld=%h alu=%h pc=%h want %h %h %h", i, obs_ld, obs_alu,
                          obs_pc, exp_ld, addr, pc);
      end
      if (is_mem) begin
        n_vec++; if (obs_addr !== {addr[31:2], 2'b00} || obs_we !== st || obs_unstable !== 0 ||
                     obs_ready_busy !== 0) begin
          n_err++; $display("FAIL rnd%0d_req got addr=%h we=%b unstable=%0d busy=%0d want %h %b 0 0",
                            i, obs_addr, obs_we, obs_unstable, obs_ready_busy, {addr[31:2], 2'b00}, st);
        end
      end
      if (is_mem && st) begin
        n_vec++; if (obs_mask !== model_mask(f3, addr) || obs_wdata !== model_wdata(f3, addr, sd)) begin
          n_err++; $display("FAIL rnd%0d_store got mask=%b wdata=%h want %b %h", i, obs_mask,
                            obs_wdata, model_mask(f3, addr), model_wdata(f3, addr, sd));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_byte_loads();
    test_store_half();
    test_trap();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the rvga core, sitting between execute and the writeback datapath. It takes one instruction from execute, performs a data-memory load or store over a valid/ready request and valid response port, and formats load data (byte/half extraction, sign/zero extension). It then presents registered pc, load result, ALU result and rd-mux select to writeback for exactly one cycle per instruction. Misaligned or illegal-width accesses are trapped here and never reach memory.

## Interface
Parameters:
- none; all data/address paths are rvga_word (32 bits)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- ex_valid_i  in  1  execute presents an instruction
- ex_ready_o  out  1  stage can accept (high only in IDLE)
- ex_pc_i  in  32  instruction pc
- ex_alu_result_i  in  32  ALU result; effective address for loads/stores
- ex_store_data_i  in  32  rs2 value for stores
- ex_funct3_i  in  3  access width/sign (RISC-V encoding)
- ex_is_load_i / ex_is_store_i  in  1 each  memory-op flags (never both)
- ex_rd_i  in  5  destination register
- ex_rdmux_sel_i  in  2  writeback rd-mux select (0 alu, 1 pc+4, 2 load)
- ex_rd_we_i  in  1  instruction writes rd
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- mem_we_o  out  1  1 = store
- mem_wmask_o  out  4  byte-lane write mask
- mem_wdata_o  out  32  lane-shifted store data
- mem_resp_valid_i  in  1  load data / store ack valid
- mem_rdata_i  in  32  raw load word
- wb_valid_o  out  1  one-cycle pulse per completed instruction
- wb_pc_o, wb_ld_result_o, wb_alu_result_o  out  32 each  to writeback
- wb_rdmux_sel_o  out  2; wb_rd_o  out  5; wb_rd_we_o  out  1
- wb_misalign_o  out  1  instruction trapped (misaligned or illegal funct3)

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: ex_ready_o=1. On ex_valid_i: latch all ex_* fields. Non-memory or trapped op -> stay IDLE, complete next cycle. Legal memory op -> REQ.
- REQ: mem_req_valid_o=1, address/mask/data held stable until mem_req_ready_i; on handshake -> RESP. mem_resp_valid_i ignored in REQ.
- RESP: wait for mem_resp_valid_i (unbounded); on it register result, -> IDLE.
- Store lanes, off=addr[1:0]: SB(000) mask 0001<<off, data byte0<<8*off; SH(001) mask 0011<<off, data half0<<8*off; SW(010) mask 1111.
- Load extract: LB/LBU byte at 8*off, LH/LHU half at 8*off, LW full word; LB/LH sign-extend, LBU/LHU zero-extend.
- Trap: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 >010. Trap -> no memory request, wb_misalign_o=1, wb_rd_we_o=0.
- Non-load completions: wb_ld_result_o=0. Stores: wb_rd_we_o=0 regardless of ex_rd_we_i.
- All wb_* outputs registered; held between pulses, meaningful only with wb_valid_o.

## Timing
- Reset (reset_n_i low at clk edge): state IDLE; mem_req_valid_o, wb_valid_o, wb_misalign_o, wb_rd_we_o=0; all data/address/mask outputs 0.
- Non-memory/trapped op: accepted cycle N, wb_valid_o high cycle N+1 only.
- Memory op, zero-wait memory: accept N, REQ N+1 (ready same cycle), RESP N+2 with resp_valid, wb_valid_o N+3. Each req-stall/resp-wait cycle adds one.
- Back-to-back: next acceptance no earlier than the cycle wb_valid_o is high (state back in IDLE).
- Reset mid-REQ/RESP: transaction abandoned, no wb pulse; stray mem_resp_valid_i in IDLE ignored.
- mem_resp_valid_i coincident with request handshake in REQ is ignored; memory must respond later.

## Test plan
- Non-mem ALU op pc=0x100, alu=0x1234, rdmux=0 -> wb_valid_o pulse next cycle, wb_alu_result_o=0x1234, wb_ld_result_o=0, rd_we passed.
- LB addr 0x2003, rdata 0x80FF_0000 -> mem_addr_o 0x2000, wb_ld_result_o 0xFFFF_FF80; LBU same -> 0x0000_0080; wb_valid at N+3.
- SH addr 0x2002, data 0x0000_ABCD -> mem_wmask_o 1100, mem_wdata_o 0xABCD_0000, mem_we_o=1, wb_rd_we_o=0.
- LW addr 0x2002 -> no mem_req_valid_o, wb_misalign_o=1 at N+1, rd_we 0; load funct3=011 same.
- LW with mem_req_ready_i low 3 cycles and resp after 2 more -> request fields stable, ex_ready_o low throughout, single wb pulse, correct data.
- reset_n_i low during RESP, then stray resp_valid -> no wb_valid_o, state IDLE, outputs zero.
